// File: rtl/sysmem_arbiter.sv
// Two-port round-robin arbiter and sequencer for a 4-lane byte-wide BRAM system memory.
// Each access runs IDLE -> ISSUE -> WAIT and returns registered read data with a one-cycle ready pulse.
module sysmem_arbiter #(
  parameter int          ADDR_W   = 10,
  parameter logic [31:0] OOR_DATA = 32'h0000_0000
) (
  input  logic              clka,
  input  logic              rsta,
  input  logic              cpu_valid,
  output logic              cpu_ready,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic [3:0]        cpu_wstrb,
  output logic [31:0]       cpu_rdata,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic [31:0]       host_addr,
  input  logic [31:0]       host_wdata,
  input  logic [3:0]        host_wstrb,
  output logic [31:0]       host_rdata,
  output logic [ADDR_W-1:0] bram_addr,
  output logic              bram_ce,
  output logic [3:0]        bram_we,
  output logic [31:0]       bram_di,
  input  logic [31:0]       bram_do,
  output logic              bus_err,
  output logic              grant_id
);

  // Handshake: a requester raises valid and holds addr/wdata/wstrb stable until
  // it sees a one-cycle ready; a port whose ready is high this cycle is not eligible.
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t state, state_nxt;

  logic              cpu_elig, host_elig, any_req, pick;
  logic [31:0]       sel_addr, sel_wdata, resp_data;
  logic [3:0]        sel_wstrb;
  logic              sel_oor;
  logic              rr_last, oor_q, rd_q;

  logic [ADDR_W-1:0] addr_d;
  logic              ce_d, cpu_ready_d, host_ready_d, bus_err_d, grant_d;
  logic              rr_d, oor_d, rd_d;
  logic [3:0]        we_d;
  logic [31:0]       di_d, cpu_rdata_d, host_rdata_d;

  always_comb begin
    cpu_elig  = cpu_valid && !cpu_ready;
    host_elig = host_valid && !host_ready;
    any_req   = cpu_elig || host_elig;
    // On a tie the port that did not win last time gets the grant.
    pick      = (cpu_elig && host_elig) ? ~rr_last : host_elig;
    sel_addr  = pick ? host_addr  : cpu_addr;
    sel_wdata = pick ? host_wdata : cpu_wdata;
    sel_wstrb = pick ? host_wstrb : cpu_wstrb;
    sel_oor   = (sel_addr >> (ADDR_W + 2)) != 32'd0;
    resp_data = oor_q ? OOR_DATA : bram_do;
  end

  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    addr_d       = bram_addr;
    ce_d         = 1'b0;
    we_d         = 4'b0000;
    di_d         = bram_di;
    cpu_ready_d  = 1'b0;
    host_ready_d = 1'b0;
    cpu_rdata_d  = cpu_rdata;
    host_rdata_d = host_rdata;
    bus_err_d    = 1'b0;
    grant_d      = grant_id;
    rr_d         = rr_last;
    oor_d        = oor_q;
    rd_d         = rd_q;
    case (state)
      IDLE: begin
        if (any_req) begin
          addr_d  = sel_addr[ADDR_W+1:2];
          di_d    = sel_wdata;
          ce_d    = !sel_oor;
          we_d    = sel_oor ? 4'b0000 : sel_wstrb;
          grant_d = pick;
          rr_d    = pick;
          oor_d   = sel_oor;
          rd_d    = (sel_wstrb == 4'b0000);
        end
      end
      WAIT: begin
        bus_err_d = oor_q;
        if (grant_id) begin
          host_ready_d = 1'b1;
          if (rd_q) host_rdata_d = resp_data;
        end else begin
          cpu_ready_d = 1'b1;
          if (rd_q) cpu_rdata_d = resp_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      bram_addr  <= '0;
      bram_ce    <= 1'b0;
      bram_we    <= 4'b0000;
      bram_di    <= 32'd0;
      cpu_ready  <= 1'b0;
      host_ready <= 1'b0;
      cpu_rdata  <= 32'd0;
      host_rdata <= 32'd0;
      bus_err    <= 1'b0;
      grant_id   <= 1'b0;
      rr_last    <= 1'b1;
      oor_q      <= 1'b0;
      rd_q       <= 1'b0;
    end else begin
      bram_addr  <= addr_d;
      bram_ce    <= ce_d;
      bram_we    <= we_d;
      bram_di    <= di_d;
      cpu_ready  <= cpu_ready_d;
      host_ready <= host_ready_d;
      cpu_rdata  <= cpu_rdata_d;
      host_rdata <= host_rdata_d;
      bus_err    <= bus_err_d;
      grant_id   <= grant_d;
      rr_last    <= rr_d;
      oor_q      <= oor_d;
      rd_q       <= rd_d;
    end
  end

endmodule

// File: tb/tb_sysmem_arbiter.sv
// Directed bench for sysmem_arbiter with a behavioural 4-lane BRAM model.
module tb_sysmem_arbiter;
  localparam int ADDR_W = 10;

  logic              clka = 1'b0;
  logic              rsta;
  logic              cpu_valid, cpu_ready, host_valid, host_ready;
  logic [31:0]       cpu_addr, cpu_wdata, cpu_rdata, host_addr, host_wdata, host_rdata;
  logic [3:0]        cpu_wstrb, host_wstrb, bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic              bram_ce, bus_err, grant_id;
  logic [31:0]       bram_di, bram_do;

  logic [7:0] mem [4][1024];
  int n_chk = 0, n_pass = 0, n_fail = 0;

  always #5 clka = ~clka;

  sysmem_arbiter #(.ADDR_W(ADDR_W), .OOR_DATA(32'h0000_0000)) dut (
    .clka(clka), .rsta(rsta),
    .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb), .cpu_rdata(cpu_rdata),
    .host_valid(host_valid), .host_ready(host_ready), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_wstrb(host_wstrb), .host_rdata(host_rdata),
    .bram_addr(bram_addr), .bram_ce(bram_ce), .bram_we(bram_we),
    .bram_di(bram_di), .bram_do(bram_do), .bus_err(bus_err), .grant_id(grant_id)
  );

  // Read-first byte lanes with one-cycle registered output.
  always @(posedge clka) begin
    if (bram_ce) begin
      for (int n = 0; n < 4; n++) begin
        if (bram_we[n]) mem[n][bram_addr] <= bram_di[8*n +: 8];
        bram_do[8*n +: 8] <= mem[n][bram_addr];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clka);
  endtask

  initial begin
    rsta = 1'b1;
    cpu_valid = 0; cpu_addr = 0; cpu_wdata = 0; cpu_wstrb = 0;
    host_valid = 0; host_addr = 0; host_wdata = 0; host_wstrb = 0;
    step(); step();
    chk("rst_ce", bram_ce, 0);
    chk("rst_we", bram_we, 0);
    chk("rst_addr", bram_addr, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_cpu_ready", cpu_ready, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    rsta = 1'b0;

    // CPU full write 0x10 <= DEADBEEF
    cpu_valid = 1; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF; cpu_wstrb = 4'hF;
    step();
    chk("wr_issue_ce", bram_ce, 1);
    chk("wr_issue_addr", bram_addr, 4);
    chk("wr_issue_we", bram_we, 4'hF);
    chk("wr_issue_di", bram_di, 32'hDEADBEEF);
    chk("wr_issue_grant", grant_id, 0);
    step();
    chk("wr_wait_ce", bram_ce, 0);
    chk("wr_wait_we", bram_we, 0);
    chk("wr_wait_ready", cpu_ready, 0);
    step();
    chk("wr_ready", cpu_ready, 1);
    chk("wr_buserr", bus_err, 0);
    cpu_valid = 0;
    step();
    chk("wr_ready_pulse", cpu_ready, 0);
    chk("wr_no_reissue", bram_ce, 0);

    // CPU read back
    cpu_valid = 1; cpu_wstrb = 4'h0; cpu_wdata = 0;
    step(); chk("rd_issue_we", bram_we, 0);
    step(); step();
    chk("rd_ready", cpu_ready, 1);
    chk("rd_data", cpu_rdata, 32'hDEADBEEF);
    cpu_valid = 0; step();

    // Partial write of byte 1
    cpu_valid = 1; cpu_wdata = 32'h0000_5A00; cpu_wstrb = 4'b0010;
    step(); chk("pw_we", bram_we, 4'b0010);
    step(); step();
    chk("pw_ready", cpu_ready, 1);
    chk("pw_rdata_kept", cpu_rdata, 32'hDEADBEEF);
    cpu_valid = 0; step();
    cpu_valid = 1; cpu_wdata = 0; cpu_wstrb = 4'h0;
    step(); step(); step();
    chk("pw_rd_data", cpu_rdata, 32'hDEAD5AEF);
    cpu_valid = 0; step();

    // Host write 0x20 <= 12345678
    host_valid = 1; host_addr = 32'h20; host_wdata = 32'h12345678; host_wstrb = 4'hF;
    step();
    chk("hw_grant", grant_id, 1);
    chk("hw_addr", bram_addr, 8);
    step(); step();
    chk("hw_ready", host_ready, 1);
    chk("hw_cpu_ready", cpu_ready, 0);
    host_valid = 0; host_wstrb = 0; host_wdata = 0; step();

    // Fresh reset, then both ports reading continuously: cpu, host, cpu, host
    rsta = 1; step(); rsta = 0;
    cpu_valid = 1; cpu_addr = 32'h10; host_valid = 1; host_addr = 32'h20;
    for (int k = 0; k < 12; k++) begin
      step();
      chk($sformatf("alt_grant_%0d", k), grant_id, ((k / 3) % 2));
      chk($sformatf("alt_ce_%0d", k), bram_ce, (k % 3) == 0);
      chk($sformatf("alt_cpu_ready_%0d", k), cpu_ready, (k % 6) == 2);
      chk($sformatf("alt_host_ready_%0d", k), host_ready, (k % 6) == 5);
      if (k % 6 == 2) chk($sformatf("alt_cpu_rdata_%0d", k), cpu_rdata, 32'hDEAD5AEF);
      if (k % 6 == 5) chk($sformatf("alt_host_rdata_%0d", k), host_rdata, 32'h12345678);
    end
    cpu_valid = 0; host_valid = 0; step();

    // Out-of-range CPU read
    cpu_valid = 1; cpu_addr = 32'h0000_1000;
    step(); chk("oor_ce0", bram_ce, 0); chk("oor_grant", grant_id, 0);
    step(); chk("oor_ce1", bram_ce, 0); chk("oor_err_early", bus_err, 0);
    step();
    chk("oor_ready", cpu_ready, 1);
    chk("oor_err", bus_err, 1);
    chk("oor_rdata", cpu_rdata, 32'h0);
    cpu_valid = 0; step();
    chk("oor_err_pulse", bus_err, 0);

    // CPU drops valid one cycle late while host is waiting
    cpu_valid = 1; cpu_addr = 32'h10;
    step(); host_valid = 1; host_addr = 32'h20;
    step(); step();
    chk("late_cpu_ready", cpu_ready, 1);
    step();
    chk("late_host_grant", grant_id, 1);
    chk("late_host_addr", bram_addr, 8);
    chk("late_cpu_ready_low", cpu_ready, 0);
    cpu_valid = 0;
    step(); step();
    chk("late_host_ready", host_ready, 1);
    chk("late_host_rdata", host_rdata, 32'h12345678);
    host_valid = 0;
    step();
    chk("late_no_cpu_reissue", bram_ce, 0);
    chk("late_cpu_quiet", cpu_ready, 0);

    // Reset asserted during WAIT of a host read
    host_valid = 1; host_addr = 32'h20;
    step(); chk("rw_issue_grant", grant_id, 1);
    step();
    rsta = 1; #1;
    chk("rw_grant", grant_id, 0);
    chk("rw_addr", bram_addr, 0);
    chk("rw_ce", bram_ce, 0);
    chk("rw_host_rdata", host_rdata, 0);
    chk("rw_cpu_rdata", cpu_rdata, 0);
    host_valid = 0;
    step();
    chk("rw_host_ready0", host_ready, 0);
    step();
    chk("rw_host_ready1", host_ready, 0);
    rsta = 0;
    cpu_valid = 1; cpu_addr = 32'h10; host_valid = 1; host_addr = 32'h20;
    step();
    chk("rw_first_grant", grant_id, 0);
    chk("rw_first_addr", bram_addr, 4);
    step(); step();
    chk("rw_cpu_ready", cpu_ready, 1);
    cpu_valid = 0;
    step();
    chk("rw_host_grant", grant_id, 1);
    step(); step();
    chk("rw_host_ready", host_ready, 1);
    host_valid = 0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/sysmem_arbiter.md
Name: sysmem_arbiter

Overview:
- Controller and two-port arbiter for the 32-bit system memory, built as four 1024x8 single-port BRAM byte lanes (NOREG output, 1-cycle read latency).
- Requester 0 is the picorv32 native memory interface; requester 1 is a host/loader port, e.g. the firmware download engine. Both ports use the same valid/ready protocol.
- Sequences every BRAM access, drives per-lane write enables from the byte strobes, and returns registered read data.

Parameters:
- ADDR_W, 10, BRAM word-address width; DEPTH = 2**ADDR_W words.
- OOR_DATA, 32'h0000_0000, read data returned for an out-of-range access.

Ports:
- clka  in  1  system clock; all state on rising edge.
- rsta  in  1  reset, asynchronous, active-high.
- cpu_valid  in  1  CPU request.
- cpu_ready  out  1  CPU completion pulse.
- cpu_addr  in  32  CPU byte address.
- cpu_wdata  in  32  CPU write data.
- cpu_wstrb  in  4  CPU byte strobes; 0 = read.
- cpu_rdata  out  32  CPU read data.
- host_valid  in  1  host request.
- host_ready  out  1  host completion pulse.
- host_addr  in  32  host byte address.
- host_wdata  in  32  host write data.
- host_wstrb  in  4  host byte strobes; 0 = read.
- host_rdata  out  32  host read data.
- bram_addr  out  ADDR_W  word address to all lanes.
- bram_ce  out  1  lane clock enable.
- bram_we  out  4  per-lane write enable; bit n = byte n.
- bram_di  out  32  write data; lane n = bits 8n+7:8n.
- bram_do  in  32  concatenated lane outputs.
- bus_err  out  1  pulses with ready on an out-of-range access.
- grant_id  out  1  requester currently owning the BRAM (0 = cpu).

Behaviour:
- Reset (async, any state): state=IDLE, bram_ce=0, bram_we=0, bram_addr=0, bram_di=0, both ready=0, both rdata=0, bus_err=0, grant_id=0, rr_last=1 (CPU wins first tie). An in-flight access is abandoned with no ready.
- FSM states: IDLE -> ISSUE -> WAIT -> IDLE.
- IDLE: select a requester. Register addr=req_addr[ADDR_W+1:2], di=wdata, we=wstrb, ce=1 (ce=0 and we=0 if out of range). Set grant_id, go ISSUE.
- ISSUE: BRAM samples ce/we/addr at the closing edge. Clear ce/we at that edge, go WAIT.
- WAIT: bram_do valid. At the closing edge, register the granted port's rdata and set its ready=1; set bus_err if out of range. Go IDLE.
- ready and bus_err are high for exactly one cycle.
- Latency: valid sampled at edge E0 -> ready high during the cycle after E2 (3 cycles). Reads and writes use the same latency.
- Reads: rdata=bram_do, or OOR_DATA if out of range. Writes leave rdata unchanged.
- Out of range: req_addr[31:ADDR_W+2] != 0. No BRAM enable; still completes with ready.
- addr[1:0] are ignored, so accesses are word-aligned.
- Requesters hold valid/addr/wdata/wstrb stable until ready.
- In the cycle a port's ready=1, that port's valid is ignored by the IDLE arbitration, because picorv32 drops valid one cycle late.
- Arbitration is round-robin:
  - Only one eligible requester: grant it.
  - Both eligible: grant the one != rr_last.
  - rr_last updates on each grant.
- No preemption. The non-granted request waits; with both ports saturating, grants alternate cpu/host.
- Only one BRAM access is in flight at a time; bram_ce is never high for two consecutive cycles.

Test Plan:
- Reset then a single CPU write: addr 0x0000_0010, wdata 0xDEADBEEF, wstrb 4'b1111 -> ISSUE cycle shows bram_addr=4, bram_we=4'hF, bram_ce=1; cpu_ready pulses 3 cycles after valid. A following read of 0x10 returns 0xDEADBEEF.
- Partial write: wstrb 4'b0010, wdata 0x0000_5A00 to addr 0x10 -> bram_we=4'b0010; a subsequent read returns 0xDEAD5AEF.
- Simultaneous cpu/host reads held high continuously -> grants alternate cpu, host, cpu, host, with the first grant to cpu after reset. Each ready is a single-cycle pulse and grant_id tracks the owner.
- Out of range: cpu read of 0x0000_1000 with ADDR_W=10 -> bram_ce stays 0, cpu_rdata=0x0, bus_err and cpu_ready pulse together at 3-cycle latency.
- CPU holds valid one cycle past ready (picorv32 timing) -> no second access is issued; the host request pending in the same cycle is granted.
- Assert rsta during WAIT of a host read -> all outputs return to reset values immediately, host_ready never pulses, and a later cpu request is granted first.
